// File: rtl/mini_alu_param_if.sv
// rtl/mini_alu_param_if.sv - pixel write valid/ready port of the mini ALU core
interface mini_alu_param_if #(
  parameter int PIX_ADDR_W = 24,
  parameter int COLOR_W    = 3
);
  logic                  oPixValid;
  logic                  iPixReady;
  logic [PIX_ADDR_W-1:0] oPixAddr;
  logic [COLOR_W-1:0]    oPixData;

  modport master (output oPixValid, output oPixAddr, output oPixData, input iPixReady);
  modport slave  (input oPixValid, input oPixAddr, input oPixData, output iPixReady);
endinterface

// File: rtl/mini_alu_param.sv
// rtl/mini_alu_param.sv - two-stage fetch/execute mini core with pixel write port
// Define MINI_ALU_MUL_EN to implement opcode 3 (MUL); otherwise it is treated as illegal.
module mini_alu_param #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 8,
  parameter int IP_W       = 16,
  parameter int PIX_ADDR_W = 24,
  parameter int COLOR_W    = 3
) (
  input  logic                  Clock,
  input  logic                  Reset,
  output logic [IP_W-1:0]       oIP,
  input  logic [4+3*ADDR_W-1:0] iInstruction,
  mini_alu_param_if.master      pix,
  output logic                  oRetire,
  output logic                  oIllegal
);
  localparam int INSTR_W = 4 + 3*ADDR_W;
  localparam int SH_W    = $clog2(DATA_W);

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_MUL = 4'h3;
  localparam logic [3:0] OP_STO = 4'h4;
  localparam logic [3:0] OP_BLE = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_PIX = 4'h7;
  localparam logic [3:0] OP_AND = 4'h8;
  localparam logic [3:0] OP_OR  = 4'h9;
  localparam logic [3:0] OP_SHL = 4'hA;
  localparam logic [3:0] OP_SHR = 4'hB;
  localparam logic [3:0] OP_BEQ = 4'hC;

  logic [IP_W-1:0]    pc;
  logic [INSTR_W-1:0] x_instr;
  logic               x_valid;
  logic [DATA_W-1:0]  x_ra;
  logic [DATA_W-1:0]  x_rb;
  logic               illegal_q;
  logic [DATA_W-1:0]  regs [2**ADDR_W];

  logic [3:0]          x_op;
  logic [ADDR_W-1:0]   x_dst;
  logic [2*ADDR_W-1:0] x_imm;
  logic [ADDR_W-1:0]   f_sa;
  logic [ADDR_W-1:0]   f_sb;
  logic [DATA_W-1:0]   f_ra;
  logic [DATA_W-1:0]   f_rb;

  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              taken;
  logic              is_pix;
  logic              is_illegal;
  logic              stall;

  assign x_op  = x_instr[INSTR_W-1 -: 4];
  assign x_dst = x_instr[3*ADDR_W-1 -: ADDR_W];
  assign x_imm = x_instr[2*ADDR_W-1:0];
  assign f_sa  = iInstruction[ADDR_W-1:0];
  assign f_sb  = iInstruction[2*ADDR_W-1:ADDR_W];

  always_comb begin
    wr_en      = 1'b0;
    wr_data    = '0;
    taken      = 1'b0;
    is_pix     = 1'b0;
    is_illegal = 1'b0;
    if (x_valid && Reset) begin
      case (x_op)
        OP_NOP: ;
        OP_ADD: begin wr_en = 1'b1; wr_data = x_rb + x_ra; end
        OP_SUB: begin wr_en = 1'b1; wr_data = x_rb - x_ra; end
`ifdef MINI_ALU_MUL_EN
        OP_MUL: begin wr_en = 1'b1; wr_data = x_rb * x_ra; end
`else
        OP_MUL: is_illegal = 1'b1;
`endif
        OP_STO: begin wr_en = 1'b1; wr_data = DATA_W'(x_imm); end
        OP_BLE: taken = (x_rb <= x_ra);
        OP_JMP: taken = 1'b1;
        OP_PIX: is_pix = 1'b1;
        OP_AND: begin wr_en = 1'b1; wr_data = x_rb & x_ra; end
        OP_OR:  begin wr_en = 1'b1; wr_data = x_rb | x_ra; end
        OP_SHL: begin wr_en = 1'b1; wr_data = x_rb << x_ra[SH_W-1:0]; end
        OP_SHR: begin wr_en = 1'b1; wr_data = x_rb >> x_ra[SH_W-1:0]; end
        OP_BEQ: taken = (x_rb == x_ra);
        default: is_illegal = 1'b1;
      endcase
    end
  end

  assign stall = is_pix && !pix.iPixReady;

  // Taken branches redirect the fetch in the same cycle, so no bubble is needed.
  assign oIP = !Reset ? '0 : (taken ? IP_W'(x_dst) : pc);

  // Write-before-read: the value being written this cycle feeds the fetch-stage read.
  assign f_ra = (wr_en && (x_dst == f_sa)) ? wr_data : regs[f_sa];
  assign f_rb = (wr_en && (x_dst == f_sb)) ? wr_data : regs[f_sb];

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      pc        <= '0;
      x_instr   <= '0;
      x_valid   <= 1'b0;
      x_ra      <= '0;
      x_rb      <= '0;
      illegal_q <= 1'b0;
    end else if (!stall) begin
      pc      <= oIP + IP_W'(1);
      x_instr <= iInstruction;
      x_valid <= 1'b1;
      x_ra    <= f_ra;
      x_rb    <= f_rb;
      if (is_illegal) illegal_q <= 1'b1;
    end
  end

  always_ff @(posedge Clock) begin
    if (wr_en) regs[x_dst] <= wr_data;
  end

  assign pix.oPixValid = is_pix;
  assign pix.oPixAddr  = PIX_ADDR_W'({x_rb, x_ra});
  assign pix.oPixData  = x_dst[ADDR_W-1 -: COLOR_W];
  assign oRetire       = x_valid && Reset && !stall;
  assign oIllegal      = illegal_q && Reset;
endmodule

// File: tb/tb_mini_alu_param.sv
// tb/tb_mini_alu_param.sv - directed table-driven bench for mini_alu_param
module tb_mini_alu_param;
  logic        clk = 1'b0;
  logic        resetn;
  logic        ready;
  logic [15:0] ip;
  logic [27:0] instr;
  logic        retire, illegal;
  logic [7:0]  ip2;
  logic [27:0] instr2;
  logic        retire2, illegal2;
  logic [27:0] rom [256];

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mini_alu_param_if #(.PIX_ADDR_W(24), .COLOR_W(3)) pif ();
  mini_alu_param_if #(.PIX_ADDR_W(24), .COLOR_W(3)) pif2 ();
  assign pif.iPixReady  = ready;
  assign pif2.iPixReady = 1'b1;

  mini_alu_param dut (
    .Clock(clk), .Reset(resetn), .oIP(ip), .iInstruction(instr),
    .pix(pif), .oRetire(retire), .oIllegal(illegal)
  );

  mini_alu_param #(.IP_W(8)) dut_wrap (
    .Clock(clk), .Reset(resetn), .oIP(ip2), .iInstruction(instr2),
    .pix(pif2), .oRetire(retire2), .oIllegal(illegal2)
  );

  always_comb instr  = (ip[15:8] == 8'h00) ? rom[ip[7:0]] : 28'h0;
  always_comb instr2 = (ip2 == 8'h00) ? {4'h6, 8'hFF, 16'h0000} : 28'h0;

  typedef struct {
    logic        ready;
    logic [15:0] ip;
    logic        ret;
    logic        pv;
    logic [23:0] addr;
    logic [2:0]  data;
    logic        ill;
  } vec_t;
  vec_t vecs[$];

  function automatic logic [27:0] ins(input logic [3:0] op, input logic [7:0] d, input logic [7:0] b, input logic [7:0] a);
    return {op, d, b, a};
  endfunction

  function automatic logic [27:0] sto(input logic [7:0] d, input logic [15:0] imm);
    return {4'h4, d, imm};
  endfunction

  task automatic add(input logic rdy, input logic [15:0] eip, input logic ret, input logic pv,
                     input logic [23:0] addr, input logic [2:0] data, input logic ill);
    vec_t v;
    v.ready = rdy; v.ip = eip; v.ret = ret; v.pv = pv; v.addr = addr; v.data = data; v.ill = ill;
    vecs.push_back(v);
  endtask

  task automatic step(input logic [15:0] eip, input logic ill);
    add(1'b1, eip, 1'b1, 1'b0, 24'h0, 3'd0, ill);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    logic        mi;
    logic [23:0] mul_probe;
`ifdef MINI_ALU_MUL_EN
    mi = 1'b0; mul_probe = 24'h020100;
`else
    mi = 1'b1; mul_probe = 24'h0200AA;
`endif
    for (int i = 0; i < 256; i++) rom[i] = 28'h0;
    rom[8'h00] = sto(8'd1, 16'd5);
    rom[8'h01] = sto(8'd2, 16'd7);
    rom[8'h02] = ins(4'h1, 8'd3, 8'd2, 8'd1);
    rom[8'h03] = ins(4'h2, 8'd4, 8'd3, 8'd1);
    rom[8'h04] = ins(4'h7, 8'h00, 8'd3, 8'd4);
    rom[8'h05] = sto(8'd1, 16'd3);
    rom[8'h06] = sto(8'd2, 16'd3);
    rom[8'h07] = ins(4'hC, 8'h20, 8'd2, 8'd1);
    rom[8'h20] = sto(8'd2, 16'd4);
    rom[8'h21] = ins(4'hC, 8'h30, 8'd2, 8'd1);
    rom[8'h22] = sto(8'd6, 16'h0012);
    rom[8'h23] = sto(8'd7, 16'h3456);
    rom[8'h24] = ins(4'h7, 8'hA0, 8'd6, 8'd7);
    rom[8'h25] = sto(8'd8, 16'h8001);
    rom[8'h26] = sto(8'd9, 16'h0011);
    rom[8'h27] = ins(4'hA, 8'd10, 8'd8, 8'd9);
    rom[8'h28] = sto(8'd11, 16'h0100);
    rom[8'h29] = sto(8'd12, 16'h0101);
    rom[8'h2A] = sto(8'd13, 16'h00AA);
    rom[8'h2B] = ins(4'h3, 8'd13, 8'd11, 8'd12);
    rom[8'h2C] = ins(4'h7, 8'h00, 8'd10, 8'd13);
    rom[8'h2D] = ins(4'h8, 8'd14, 8'd8, 8'd9);
    rom[8'h2E] = ins(4'h9, 8'd15, 8'd8, 8'd9);
    rom[8'h2F] = ins(4'hB, 8'd5, 8'd8, 8'd9);
    rom[8'h30] = ins(4'h5, 8'h40, 8'd9, 8'd8);
    rom[8'h40] = ins(4'h7, 8'h00, 8'd15, 8'd14);
    rom[8'h41] = ins(4'h7, 8'h00, 8'd5, 8'd5);
    rom[8'h42] = ins(4'h5, 8'h50, 8'd8, 8'd9);
    rom[8'h43] = ins(4'h6, 8'h60, 8'd0, 8'd0);
    rom[8'h60] = ins(4'hE, 8'h00, 8'd0, 8'd0);
    rom[8'h61] = ins(4'h7, 8'hE0, 8'd6, 8'd7);

    // Expected state per cycle after reset release (cycle N executes the word fetched in N-1).
    step(16'h01, 0); step(16'h02, 0); step(16'h03, 0); step(16'h04, 0);
    add(1, 16'h05, 1, 1, 24'h0C0007, 3'd0, 0);
    step(16'h06, 0); step(16'h07, 0); step(16'h20, 0); step(16'h21, 0);
    step(16'h22, 0); step(16'h23, 0); step(16'h24, 0);
    for (int k = 0; k < 3; k++) add(0, 16'h25, 0, 1, 24'h123456, 3'd5, 0);
    add(1, 16'h25, 1, 1, 24'h123456, 3'd5, 0);
    step(16'h26, 0); step(16'h27, 0); step(16'h28, 0); step(16'h29, 0);
    step(16'h2A, 0); step(16'h2B, 0); step(16'h2C, 0);
    add(1, 16'h2D, 1, 1, mul_probe, 3'd0, mi);
    step(16'h2E, mi); step(16'h2F, mi); step(16'h30, mi); step(16'h40, mi);
    add(1, 16'h41, 1, 1, 24'h110001, 3'd0, mi);
    add(1, 16'h42, 1, 1, 24'h004000, 3'd0, mi);
    step(16'h43, mi); step(16'h60, mi); step(16'h61, mi);
    add(0, 16'h62, 0, 1, 24'h123456, 3'd7, 1);

    resetn = 1'b0;
    ready  = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_ip", 32'(ip), 32'h0);
    chk("reset_pv", 32'(pif.oPixValid), 32'h0);
    chk("reset_retire", 32'(retire), 32'h0);
    chk("reset_illegal", 32'(illegal), 32'h0);
    resetn = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1 ready = vecs[i].ready;
      @(negedge clk);
      chk($sformatf("c%0d_ip", i+1), 32'(ip), 32'(vecs[i].ip));
      chk($sformatf("c%0d_retire", i+1), 32'(retire), 32'(vecs[i].ret));
      chk($sformatf("c%0d_pv", i+1), 32'(pif.oPixValid), 32'(vecs[i].pv));
      chk($sformatf("c%0d_illegal", i+1), 32'(illegal), 32'(vecs[i].ill));
      if (vecs[i].pv) begin
        chk($sformatf("c%0d_addr", i+1), 32'(pif.oPixAddr), 32'(vecs[i].addr));
        chk($sformatf("c%0d_data", i+1), 32'(pif.oPixData), 32'(vecs[i].data));
      end
      chk($sformatf("c%0d_wrap_ip", i+1), 32'(ip2), (i % 2 == 0) ? 32'hFF : 32'h00);
    end

    // Stall continues, then reset lands in the middle of it.
    @(posedge clk);
    #1 ready = 1'b0;
    @(negedge clk);
    chk("stall_ip", 32'(ip), 32'h62);
    chk("stall_pv", 32'(pif.oPixValid), 32'h1);
    chk("stall_retire", 32'(retire), 32'h0);
    chk("stall_illegal", 32'(illegal), 32'h1);
    @(posedge clk);
    #1 resetn = 1'b0;
    @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    chk("post_reset_pv", 32'(pif.oPixValid), 32'h0);
    chk("post_reset_illegal", 32'(illegal), 32'h0);
    chk("post_reset_ip", 32'(ip), 32'h0);
    chk("post_reset_retire", 32'(retire), 32'h0);
    @(posedge clk);
    #1 ready = 1'b1;
    @(negedge clk);
    chk("restart_ip", 32'(ip), 32'h1);
    chk("restart_retire", 32'(retire), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/mini_alu_param.md
# mini_alu_param

Parametrised two-stage mini-processor core for the VGA experiments: fetches instructions from an external ROM, executes ALU, branch and immediate-store ops on an internal register file, and issues pixel writes to video memory over a valid/ready port. It generalises data, register-address, IP and pixel widths. It adds write-before-read forwarding, stall-on-backpressure pixel writes, logic/shift/BEQ ops, an illegal-op flag and a retire strobe.

## Interface
- DATA_W, 16, register and ALU width
- ADDR_W, 8, register-address field width; register file depth is 2**ADDR_W; instruction width is 4+3*ADDR_W
- IP_W, 16, instruction-pointer width
- PIX_ADDR_W, 24, pixel address width (must be ≤ 2*DATA_W)
- COLOR_W, 3, pixel data width (must be ≤ ADDR_W)
- Clock  in  1  rising-edge clock
- Reset  in  1  synchronous, active-low reset
- oIP  out  IP_W  fetch address to ROM
- iInstruction  in  4+3*ADDR_W  ROM data for oIP, combinational, same cycle
- oPixValid  out  1  pixel write request
- iPixReady  in  1  video memory accepts the request
- oPixAddr  out  PIX_ADDR_W  {rB,rA} truncated to the low PIX_ADDR_W bits
- oPixData  out  COLOR_W  colour, from the top COLOR_W bits of the DST field
- oRetire  out  1  one-cycle pulse per completed instruction
- oIllegal  out  1  sticky flag, set by an undefined opcode

## Operation
- Instruction fields: OP [top 4 bits], DST [3*ADDR_W-1:2*ADDR_W], SB [2*ADDR_W-1:ADDR_W], SA [ADDR_W-1:0]. rA = reg[SA], rB = reg[SB]. IMM = {SB,SA}, zero-extended or truncated to DATA_W.
- Stage F: oIP drives the ROM. Register reads at SA/SB are captured synchronously with the instruction into the execute register.
- Stage X: execute the registered instruction.
- Opcodes:
  - 0 NOP.
  - 1 ADD: DST=rB+rA. 2 SUB: DST=rB−rA. Both are modulo 2**DATA_W.
  - 3 MUL: DST=low DATA_W bits of the unsigned rB*rA.
  - 4 STO: DST=IMM.
  - 5 BLE: branch to DST if rB ≤ rA, unsigned.
  - 6 JMP: branch to DST.
  - 7 PIX: pixel write.
  - 8 AND: DST=rB&rA. 9 OR: DST=rB|rA.
  - A SHL: DST=rB<<rA[log2(DATA_W)-1:0]. B SHR: same amount, logical shift right.
  - C BEQ: branch to DST if rB==rA.
  - D–F: illegal. Executes as NOP, sets oIllegal, still retires.
- Branch target is DST zero-extended to IP_W. When taken, oIP equals the target in the same cycle (combinational). No bubble, no squash.
- Forwarding: a register-file write in cycle N whose address equals SA or SB of the instruction being fetched in cycle N supplies the new value to that read.
- The register file is not reset; contents are undefined until written.

## Timing
- While Reset=0: oIP=0, execute register=NOP, oPixValid=0, oRetire=0, oIllegal=0.
- The first rising edge with Reset=1 latches the instruction at address 0; it executes in the next cycle.
- Throughput is one instruction per cycle with no stalls. Result latency is 1; forwarding gives back-to-back dependent ops with no penalty.
- PIX handshake:
  - oPixValid is 1 whenever X holds PIX. It does not depend on iPixReady.
  - oPixAddr and oPixData stay stable while valid.
  - Transfer happens on the edge where oPixValid&iPixReady=1. oRetire pulses in that cycle.
- Stall (PIX with iPixReady=0):
  - PC, execute register and sticky state are frozen; oIP is held.
  - There are no register writes and oRetire=0.
  - The fetch stage re-reads, so forwarding stays correct.
- PC wraps from 2**IP_W−1 to 0.
- Reset asserted mid-stall or mid-branch: on the next edge everything returns to reset values and the pending pixel request is dropped.

## Configuration
- MINI_ALU_MUL_EN defined: opcode 3 is implemented as specified.
- MINI_ALU_MUL_EN undefined: no multiplier is instantiated; opcode 3 is illegal (NOP, sets oIllegal, retires).

## Test plan
- Reset then STO r1=5, STO r2=7, ADD r3=r2+r1, immediately followed by SUB r4=r3−r1 -> r3=12, r4=7 via forwarding; oRetire high 4 consecutive cycles.
- STO r1=3, STO r2=3, BEQ to 0x20 -> oIP=0x20 in the BEQ execute cycle; the next retired instruction is from 0x20. Repeat with r2=4 -> falls through to PC+1.
- PIX with rB=0x0012, rA=0x3456, DST top bits=3'b101, iPixReady low for 3 cycles -> oPixAddr=0x123456, oPixData=5; oPixValid held 4 cycles; oIP frozen; exactly one transfer.
- MUL with rB=0x0100, rA=0x0101 -> with MINI_ALU_MUL_EN, DST=0x0100 (truncated). Without it, DST unchanged and oIllegal=1.
- Opcode 0xE, then Reset low for one cycle during a stalled PIX -> oIllegal=1 before reset. After reset: oIllegal=0, oPixValid=0, oIP=0.
- SHL rB=0x8001 by rA=0x0011 (DATA_W=16) -> amount 1, DST=0x0002. PC at 0xFFFF with NOP -> next oIP=0x0000.
